// File: rtl/pipe_pkg.sv
// Shared pipeline constants: forward-select encodings, Tuse sentinel and
// default mult/div latencies.
package pipe_pkg;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_M     = 2'd1;
    localparam logic [1:0] FWD_E     = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_busy_counter.sv
// Mult/div occupancy countdown: loads on start (restart allowed while busy),
// decrements to zero, reports busy combinationally.
module md_busy_counter #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    logic [CNT_W-1:0] md_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (start) begin
            md_cnt <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end

    assign busy = start | (md_cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline; all outputs are
// combinational and forced low while reset is asserted.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_tuse_rs,
    input  logic [1:0] D_tuse_rt,
    input  logic       D_is_md,
    input  logic       D_branch_taken,
    input  logic [4:0] E_wa,
    input  logic [1:0] E_tnew,
    input  logic [4:0] M_wa,
    input  logic [1:0] M_tnew,
    input  logic       E_md_start,
    input  logic       E_md_div,
    output logic       F_Stall,
    output logic       D_Stall,
    output logic       D_Flush,
    output logic       E_Flush,
    output logic [1:0] D_fwd_rs,
    output logic [1:0] D_fwd_rt,
    output logic       md_busy
);

    logic cnt_busy;
    logic stall_rs;
    logic stall_rt;
    logic stall_md;
    logic stall;

    md_busy_counter #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_md_cnt (
        .clk   (clk),
        .reset (reset),
        .start (E_md_start),
        .is_div(E_md_div),
        .busy  (cnt_busy)
    );

    function automatic logic reg_stall(input logic [4:0] r, input logic [1:0] tuse,
                                       input logic [4:0] e_wa, input logic [1:0] e_tnew,
                                       input logic [4:0] m_wa, input logic [1:0] m_tnew);
        return (r != 5'd0) &&
               (((r == e_wa) && (e_tnew > tuse)) || ((r == m_wa) && (m_tnew > tuse)));
    endfunction

    // E is checked first so the newest in-flight value wins.
    function automatic logic [1:0] fwd_sel(input logic [4:0] r,
                                           input logic [4:0] e_wa, input logic [1:0] e_tnew,
                                           input logic [4:0] m_wa, input logic [1:0] m_tnew);
        if (r == 5'd0)                         return FWD_RF;
        else if (r == e_wa && e_tnew == 2'd0)  return FWD_E;
        else if (r == m_wa && m_tnew == 2'd0)  return FWD_M;
        else                                   return FWD_RF;
    endfunction

    always_comb begin
        stall_rs = reg_stall(D_rs, D_tuse_rs, E_wa, E_tnew, M_wa, M_tnew);
        stall_rt = reg_stall(D_rt, D_tuse_rt, E_wa, E_tnew, M_wa, M_tnew);
        stall_md = D_is_md & cnt_busy;
        stall    = stall_rs | stall_rt | stall_md;
    end

    // A stall outranks a flush so the held D instruction survives.
    always_comb begin
        F_Stall  = 1'b0;
        D_Stall  = 1'b0;
        E_Flush  = 1'b0;
        D_Flush  = 1'b0;
        D_fwd_rs = FWD_RF;
        D_fwd_rt = FWD_RF;
        md_busy  = 1'b0;
        if (!reset) begin
            F_Stall  = stall;
            D_Stall  = stall;
            E_Flush  = stall;
            D_Flush  = D_branch_taken & ~stall;
            D_fwd_rs = fwd_sel(D_rs, E_wa, E_tnew, M_wa, M_tnew);
            D_fwd_rt = fwd_sel(D_rt, E_wa, E_tnew, M_wa, M_tnew);
            md_busy  = cnt_busy;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: data stalls, forwarding, mult/div busy
// window, branch flush vs stall priority, and reset behaviour.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_rs, D_rt, E_wa, M_wa;
    logic [1:0] D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
    logic       D_is_md, D_branch_taken, E_md_start, E_md_div;
    logic       F_Stall, D_Stall, D_Flush, E_Flush, md_busy;
    logic [1:0] D_fwd_rs, D_fwd_rt;

    int checks = 0;
    int errors = 0;
    int cnt;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .D_rs          (D_rs),
        .D_rt          (D_rt),
        .D_tuse_rs     (D_tuse_rs),
        .D_tuse_rt     (D_tuse_rt),
        .D_is_md       (D_is_md),
        .D_branch_taken(D_branch_taken),
        .E_wa          (E_wa),
        .E_tnew        (E_tnew),
        .M_wa          (M_wa),
        .M_tnew        (M_tnew),
        .E_md_start    (E_md_start),
        .E_md_div      (E_md_div),
        .F_Stall       (F_Stall),
        .D_Stall       (D_Stall),
        .D_Flush       (D_Flush),
        .E_Flush       (E_Flush),
        .D_fwd_rs      (D_fwd_rs),
        .D_fwd_rt      (D_fwd_rt),
        .md_busy       (md_busy)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Outputs packed as {F_Stall,D_Stall,E_Flush,D_Flush}
    function automatic logic [7:0] ctl();
        return {4'b0, F_Stall, D_Stall, E_Flush, D_Flush};
    endfunction

    task automatic clear_inputs();
        D_rs = 0; D_rt = 0; D_tuse_rs = 2'd3; D_tuse_rt = 2'd3;
        D_is_md = 0; D_branch_taken = 0;
        E_wa = 0; E_tnew = 0; M_wa = 0; M_tnew = 0;
        E_md_start = 0; E_md_div = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with every hazard source active: outputs must stay low
        clear_inputs();
        reset = 1;
        D_rs = 5'd1; D_tuse_rs = 2'd0; E_wa = 5'd1; E_tnew = 2'd2;
        D_rt = 5'd2; M_wa = 5'd2; M_tnew = 2'd0; D_branch_taken = 1;
        E_md_start = 1; D_is_md = 1;
        #1;
        chk("rst_ctl", ctl(), 8'h0);
        chk("rst_fwd_rt", D_fwd_rt, 0);
        chk("rst_busy", md_busy, 0);
        tick();
        reset = 0;
        clear_inputs();
        tick();
        chk("post_rst_busy", md_busy, 0);
        chk("idle_ctl", ctl(), 8'h0);

        // lw $1 in E, addu in D needs $1 next cycle
        D_rs = 5'd1; D_tuse_rs = 2'd1; E_wa = 5'd1; E_tnew = 2'd2;
        #1;
        chk("lw_stall", ctl(), 8'b1110);
        tick();
        E_wa = 5'd0; E_tnew = 2'd0; M_wa = 5'd1; M_tnew = 2'd1;
        #1;
        chk("lw_m_nostall", ctl(), 8'h0);
        chk("lw_m_fwd_rf", D_fwd_rs, 0);
        tick();
        M_tnew = 2'd0;
        #1;
        chk("lw_m_fwd_m", D_fwd_rs, 1);

        // Register 0 never stalls or forwards
        clear_inputs();
        D_rs = 5'd0; D_tuse_rs = 2'd0; E_wa = 5'd0; E_tnew = 2'd2;
        #1;
        chk("r0_ctl", ctl(), 8'h0);
        chk("r0_fwd", D_fwd_rs, 0);

        // E has priority over M for forwarding
        clear_inputs();
        D_rt = 5'd5; E_wa = 5'd5; M_wa = 5'd5;
        #1;
        chk("fwd_e_prio", D_fwd_rt, 2);
        chk("fwd_e_rs_rf", D_fwd_rs, 0);

        // Branch taken while rt hazard stalls: stall wins
        clear_inputs();
        D_rt = 5'd3; D_tuse_rt = 2'd0; E_wa = 5'd3; E_tnew = 2'd1;
        D_branch_taken = 1;
        #1;
        chk("br_stall_wins", ctl(), 8'b1110);
        tick();
        E_wa = 5'd0; E_tnew = 2'd0;
        #1;
        chk("br_flush", ctl(), 8'b0001);

        // Div: stall window = start cycle + 10
        clear_inputs();
        tick();
        E_md_start = 1; E_md_div = 1; D_is_md = 1;
        cnt = 0;
        #1;
        if (F_Stall) cnt++;
        tick();
        E_md_start = 0; E_md_div = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (F_Stall) cnt++;
            tick();
        end
        chk("div_stall_cycles", cnt[7:0], 11);
        chk("div_busy_done", md_busy, 0);

        // Mult: 6-cycle window
        E_md_start = 1; E_md_div = 0;
        cnt = 0;
        #1;
        if (D_Stall) cnt++;
        tick();
        E_md_start = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (D_Stall) cnt++;
            tick();
        end
        chk("mult_stall_cycles", cnt[7:0], 6);

        // Restart while busy reloads the count
        E_md_start = 1; E_md_div = 0;
        tick();
        E_md_start = 0;
        tick(); tick();
        E_md_start = 1; E_md_div = 0;
        tick();
        E_md_start = 0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (md_busy) cnt++;
            tick();
        end
        chk("restart_busy_cycles", cnt[7:0], 5);

        // Reset mid-countdown at md_cnt=7 aborts it
        E_md_start = 1; E_md_div = 1;
        tick();
        E_md_start = 0;
        tick(); tick(); tick();
        #1;
        chk("pre_rst_busy", md_busy, 1);
        reset = 1;
        D_rs = 5'd4; D_tuse_rs = 2'd0; E_wa = 5'd4; E_tnew = 2'd1;
        #1;
        chk("mid_rst_ctl", ctl(), 8'h0);
        chk("mid_rst_busy", md_busy, 0);
        tick();
        reset = 0;
        clear_inputs();
        D_is_md = 1;
        #1;
        chk("after_rst_busy", md_busy, 0);
        chk("after_rst_ctl", ctl(), 8'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central stall/flush/forward controller for the 5-stage pipeline.
- Watches register-use timing (Tuse in D, Tnew in E/M) and the multi-cycle mult/div unit.
- Drives F_Stall, D_Stall and D_Flush for the fetch stage and FD register, E_Flush for the DE register, and D-stage forward selects.
- Owns the mult/div busy countdown. This is the only sequential state in the block.

Parameters:
MULT_CYCLES, 5, busy cycles after a mult/multu start
DIV_CYCLES, 10, busy cycles after a div/divu start
CNT_W, 4, busy counter width; must hold DIV_CYCLES

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
D_rs  in  5  rs field of instruction in D
D_rt  in  5  rt field of instruction in D
D_tuse_rs  in  2  cycles until D instr needs rs (3 = not used)
D_tuse_rt  in  2  cycles until D instr needs rt (3 = not used)
D_is_md  in  1  D instr is mult/div/mfhi/mflo/mthi/mtlo
D_branch_taken  in  1  branch/jump resolved taken in D
E_wa  in  5  destination register of E instr (0 = none)
E_tnew  in  2  cycles until E result is available
M_wa  in  5  destination register of M instr
M_tnew  in  2  cycles until M result is available
E_md_start  in  1  E instr launches mult/div this cycle
E_md_div  in  1  with E_md_start: 1 = div, 0 = mult
F_Stall  out  1  hold PC
D_Stall  out  1  hold FD register
D_Flush  out  1  clear FD register (delay-slot-less squash)
E_Flush  out  1  insert bubble into DE register
D_fwd_rs  out  2  0 = RF, 1 = from M, 2 = from E
D_fwd_rt  out  2  same encoding for rt
md_busy  out  1  mult/div unit occupied

Behaviour:
Busy counter (md_cnt, CNT_W bits):
- Reset: md_cnt = 0.
- E_md_start=1: load MULT_CYCLES or DIV_CYCLES per E_md_div. Reload also applies if already busy; E_md_start while busy is legal and restarts the count.
- Else if md_cnt != 0: decrement.
- Never wraps below 0.
- md_busy = E_md_start | (md_cnt != 0), combinational.

Data hazard:
- stall_rs = (D_rs != 0) & ((D_rs == E_wa & E_tnew > D_tuse_rs) | (D_rs == M_wa & M_tnew > D_tuse_rs)). stall_rt is the same with rt.
- stall_md = D_is_md & md_busy.
- stall = stall_rs | stall_rt | stall_md.
- Register 0 never causes a stall or a forward.

Outputs (all combinational, same cycle as inputs):
- F_Stall = D_Stall = E_Flush = stall.
- D_Flush = D_branch_taken & ~stall. A stall always wins over a flush, so the instruction held in D is not lost; the flush is re-evaluated when the stall releases.

Forwarding, for each of rs and rt:
- 2 if reg != 0, reg == E_wa and E_tnew == 0.
- Else 1 if reg != 0, reg == M_wa and M_tnew == 0.
- Else 0.
- E has priority over M (newest value). W-stage values reach D through RF write-through and are not forwarded here.

Reset:
- While reset=1, all outputs are forced to 0 regardless of inputs.
- md_cnt clears at the next edge.
- Reset mid-countdown aborts the countdown: md_busy = 0 on the cycle after reset.

Decomposition:
- Shared package pipe_pkg: FWD_RF=0, FWD_M=1, FWD_E=2; TUSE_NONE=3; MULT_CYCLES and DIV_CYCLES defaults.
- One natural sub-module, md_busy_counter (load / decrement / busy flag), instantiated once.
- Hazard compare and forward logic stay flat in hazard_ctrl.

Test Plan:
- lw $1 in E (E_wa=1, E_tnew=2), D addu using $1 (D_tuse_rs=1) -> F_Stall=D_Stall=E_Flush=1, D_Flush=0. Next cycle E_wa=0, M_wa=1, M_tnew=1 -> stall=0, D_fwd_rs=0; following cycle M_tnew=0 -> D_fwd_rs=1.
- D_rs=0 with E_wa=0, E_tnew=2 -> no stall, D_fwd_rs=0.
- E_md_start=1, E_md_div=1, then D_is_md=1 -> stall held exactly 11 cycles (start cycle + 10 countdown); md_busy drops when md_cnt reaches 0. Repeat with mult -> 6 cycles.
- D_branch_taken=1 together with stall_rt=1 -> D_Flush=0, stall=1. After the hazard clears with branch still taken -> D_Flush=1, stall=0.
- E_wa=M_wa=5, E_tnew=0, M_tnew=0, D_rt=5 -> D_fwd_rt=2 (E priority).
- Assert reset for 1 cycle at md_cnt=7 -> outputs 0 during reset; md_cnt=0 and md_busy=0 after release.
